hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core.
- Drives enable/flush of the IF/ID, ID/EX (incl. flush_IDEX), EX/MEM and MEM/WB latches and the PC enable.
- Resolves load-use hazards, taken branches/jumps, instruction-fetch misses, data-memory waits and halt.
- Holds a small FSM (RUN/DWAIT/HALTED) so multi-cycle memory waits and halt are sequenced cleanly.

---
 rtl/hazard_ctrl_if.sv | 20 ++
 rtl/hazard_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and pipeline latch controls of the hazard controller
interface hazard_ctrl_if #(parameter int REGW = 5, parameter int CNTW = 16);
  logic ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread;
  logic [REGW-1:0] idex_wsel, ifid_rs, ifid_rt;
  logic ifid_uses_rt, branch_taken, memwb_halt;
  logic pc_en, ifid_en, ifid_flush, idex_en, flush_IDEX, exmem_en, memwb_en, halted;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread, idex_wsel, ifid_rs, ifid_rt,
           ifid_uses_rt, branch_taken, memwb_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, flush_IDEX, exmem_en, memwb_en, halted,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread, idex_wsel, ifid_rs, ifid_rt,
           ifid_uses_rt, branch_taken, memwb_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, flush_IDEX, exmem_en, memwb_en, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush sequencer; HAZARD_PERF_CNT_EN builds stall/flush counters
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input logic CLK,
  input logic nRST,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  state_t state, state_n;
  logic dmem_pend, load_use;
  logic [REGW-1:0] wsel;
  assign wsel = hz.idex_wsel;
  assign dmem_pend = (hz.exmem_dREN | hz.exmem_dWEN) & ~hz.dhit;
  assign load_use = hz.idex_memread & (wsel != '0) &
                    ((wsel == hz.ifid_rs) | (hz.ifid_uses_rt & (wsel == hz.ifid_rt)));
  always_ff @(posedge CLK)
    state <= !nRST ? RUN : state_n;
  always_comb begin
    state_n = state;
    hz.pc_en = 1'b1;
    hz.ifid_en = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_en = 1'b1;
    hz.flush_IDEX = 1'b0;
    hz.exmem_en = 1'b1;
    hz.memwb_en = 1'b1;
    hz.halted = 1'b0;
    if (!nRST) begin
      {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '0;
      hz.ifid_flush = 1'b1;
      hz.flush_IDEX = 1'b1;
    end else if (state == HALTED) begin
      {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '0;
      hz.halted = 1'b1;
    end else if (dmem_pend) begin
      {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = '0;
      state_n = DWAIT;
    end else if (hz.memwb_halt) begin
      {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en} = '0;
      state_n = HALTED;
    end else begin
      state_n = RUN;
      // a taken branch squashes the hazard-causing instruction, so it wins over load_use
      if (hz.branch_taken) begin
        hz.ifid_flush = 1'b1;
        hz.flush_IDEX = 1'b1;
      end else if (load_use) begin
        hz.pc_en = 1'b0;
        hz.ifid_en = 1'b0;
        hz.flush_IDEX = 1'b1;
      end else if (!hz.ihit) begin
        hz.pc_en = 1'b0;
        hz.ifid_flush = 1'b1;
      end
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic stall, flush;
  logic [CNTW-1:0] stall_q, flush_q;
  // PC held and not the halt-drain cycle (which alone has memwb_en without exmem_en)
  assign stall = nRST & (state != HALTED) & ~hz.pc_en & (hz.exmem_en | ~hz.memwb_en);
  assign flush = hz.pc_en & hz.ifid_flush;
  always_ff @(posedge CLK)
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && !(&stall_q)) stall_q <= stall_q + CNTW'(1);
      if (flush && !(&flush_q)) flush_q <= flush_q + CNTW'(1);
    end
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = {CNTW{1'b0}};
  assign hz.flush_cnt = {CNTW{1'b0}};
`endif
endmodule
